uart_rx_oversampler: RTL

- Parametrised successor of the UART RX data-sampling stage.
- Owns its own per-bit oversampling edge counter and takes a configurable odd number of samples centred on mid-bit.
- Resolves each bit by majority vote and reports the result with a valid strobe and a noise flag.
- Sits between the RX_IN pin and the UART RX FSM (start-check, parity-check and stop-check consumers).

---
 rtl/uart_rx_oversampler.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/uart_rx_oversampler.sv
// UART RX oversampler: per-bit edge counter with a mid-bit majority vote over SAMPLES samples.
// Define UART_RX_SYNC_EN to pass RX_IN through a 2-flop synchroniser before sampling.
module uart_rx_oversampler #(
    parameter int unsigned PRESCALE_W = 6,
    parameter int unsigned SAMPLES    = 3
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  samp_en,
    input  logic [PRESCALE_W-1:0] Prescale,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic                  bit_done,
    output logic                  sampled_bit,
    output logic                  sample_valid,
    output logic                  noise_err
);

    localparam int unsigned PW  = PRESCALE_W;
    localparam int unsigned EW  = PRESCALE_W + 1;
    localparam int unsigned H   = (SAMPLES - 1) / 2;
    localparam int unsigned SCW = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic                rx_s;
    logic                start_c;
    logic                run_c;
    logic [PW-1:0]       last_c;
    logic                wrap_c;
    logic [PW-1:0]       cnt_nxt_c;
    logic [EW-1:0]       center_c;
    logic [EW-1:0]       win_lo_c;
    logic [EW-1:0]       win_hi_c;
    logic [EW-1:0]       cnt_ext_c;
    logic                legal_c;
    logic                in_win_c;
    logic                final_c;
    logic                full_c;
    logic [SAMPLES-1:0]  vote_q;
    logic [SAMPLES-1:0]  vote_nxt_c;
    logic [SCW-1:0]      samp_cnt_q;

    function automatic logic majority(input logic [SAMPLES-1:0] v);
        int unsigned ones;
        ones = 0;
        for (int i = 0; i < int'(SAMPLES); i++) begin
            ones += 32'(v[i]);
        end
        return (ones > H);
    endfunction

`ifdef UART_RX_SYNC_EN
    logic [1:0] sync_q;

    // Two-stage synchroniser; idles high like the line.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], RX_IN};
        end
    end

    assign rx_s = sync_q[1];
`else
    assign rx_s = RX_IN;
`endif

    // State register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (samp_en)  state_nxt = COUNT;
            COUNT:   if (!samp_en) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: the IDLE cycle that sees samp_en counts as edge 0 of the first bit.
    always_comb begin
        start_c = 1'b0;
        run_c   = 1'b0;
        case (state)
            IDLE:    start_c = samp_en;
            COUNT:   run_c   = samp_en;
            default: begin
                start_c = 1'b0;
                run_c   = 1'b0;
            end
        endcase
    end

    assign last_c    = Prescale - PW'(1);
    assign wrap_c    = (edge_cnt >= last_c);
    assign cnt_nxt_c = (start_c || run_c) ? (wrap_c ? '0 : edge_cnt + PW'(1)) : '0;

    // Sample window [C-H, C+H] around mid-bit; only meaningful for legal Prescale.
    assign center_c  = EW'(Prescale >> 1);
    assign win_lo_c  = center_c - EW'(H);
    assign win_hi_c  = center_c + EW'(H);
    assign cnt_ext_c = EW'(edge_cnt);
    assign legal_c   = (EW'(Prescale) >= EW'(SAMPLES + 2));
    assign in_win_c  = run_c && legal_c && (cnt_ext_c >= win_lo_c) && (cnt_ext_c <= win_hi_c);
    assign final_c   = in_win_c && (cnt_ext_c == win_hi_c);
    assign full_c    = (samp_cnt_q == SCW'(SAMPLES - 1));

    assign vote_nxt_c = (vote_q << 1) | SAMPLES'(rx_s);

    // Edge counter and bit boundary pulse.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt <= '0;
            bit_done <= 1'b0;
        end else begin
            edge_cnt <= cnt_nxt_c;
            bit_done <= (start_c || run_c) && (cnt_nxt_c == last_c);
        end
    end

    // Vote collection; cleared on wrap or whenever the frame is not running.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            vote_q     <= '0;
            samp_cnt_q <= '0;
        end else if (!run_c || wrap_c) begin
            vote_q     <= '0;
            samp_cnt_q <= '0;
        end else if (in_win_c) begin
            vote_q     <= vote_nxt_c;
            samp_cnt_q <= samp_cnt_q + SCW'(1);
        end
    end

    // Resolved bit, noise flag and strobe; bit and flag hold between strobes.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sampled_bit  <= 1'b1;
            sample_valid <= 1'b0;
            noise_err    <= 1'b0;
        end else begin
            sample_valid <= final_c && full_c;
            if (final_c && full_c) begin
                sampled_bit <= majority(vote_nxt_c);
                noise_err   <= !((&vote_nxt_c) || (~|vote_nxt_c));
            end
        end
    end

endmodule
